// File: rtl/apb_rr_requester_arbiter.sv
// apb_rr_requester_arbiter
// Two request/acknowledge clients share one APB3 completer. Clients are served
// round-robin, one SETUP/ACCESS transfer at a time. A client may hold a lock so
// that its back-to-back transfers are not interleaved with the other client.
// An ACCESS phase that sees PREADY low for TIMEOUT cycles is aborted with err.
module apb_rr_requester_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Last ACCESS cycle index allowed with PREADY low before the abort.
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_last_grant;   // also the current winner while a transfer runs
    logic              r_locked;
    logic [7:0]        r_tcnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;

    logic              w_owner_req;
    logic              w_owner_lock;
    logic              w_release;
    logic              w_lock_hold;
    logic              w_grant_vld;
    logic              w_winner;

    // Pick the next client: lock owner only while the lock holds, otherwise round-robin.
    always_comb begin
        w_owner_req  = r_last_grant ? req1  : req0;
        w_owner_lock = r_last_grant ? lock1 : lock0;
        // An idle owner that has also dropped its lock gives the bus back right away.
        w_release    = r_locked && !w_owner_req && !w_owner_lock;
        w_lock_hold  = r_locked && !w_release;
        w_grant_vld  = 1'b0;
        w_winner     = 1'b0;
        if (w_lock_hold) begin
            w_grant_vld = w_owner_req;
            w_winner    = r_last_grant;
        end else if (req0 && req1) begin
            w_grant_vld = 1'b1;
            w_winner    = ~r_last_grant;
        end else begin
            w_grant_vld = req0 | req1;
            w_winner    = req1;
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS (wait/timeout) -> DONE, all outputs registered.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_locked     <= 1'b0;
            r_tcnt       <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pwrite     <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_release) begin
                        r_locked <= 1'b0;
                    end
                    if (w_grant_vld) begin
                        r_last_grant <= w_winner;
                        r_paddr      <= w_winner ? addr1  : addr0;
                        r_pwdata     <= w_winner ? wdata1 : wdata0;
                        r_pwrite     <= w_winner ? write1 : write0;
                        r_psel       <= 1'b1;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_tcnt    <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_locked  <= w_owner_lock;
                        r_state   <= ST_DONE;
                        if (r_last_grant) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= 1'b0;
                            r_rdata1 <= r_pwrite ? '0 : PRDATA;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= 1'b0;
                            r_rdata0 <= r_pwrite ? '0 : PRDATA;
                        end
                    end else if (r_tcnt == TCNT_LAST) begin
                        // Completer never answered: abort, report err and drop any lock.
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_locked  <= 1'b0;
                        r_state   <= ST_DONE;
                        if (r_last_grant) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= 1'b1;
                            r_rdata1 <= '0;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= 1'b1;
                            r_rdata0 <= '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PWRITE  = r_pwrite;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;

endmodule

// File: tb/tb_apb_rr_requester_arbiter.sv
// Bench for apb_rr_requester_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_apb_rr_requester_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [1:0]  lk;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY;

    // completer configuration (written by stimulus) and state (written by completer)
    int          slv_wait;
    logic [31:0] slv_base;
    logic [31:0] slv_inc;
    int unsigned slv_n;
    int          acc_cnt;

    int n_pass;
    int n_total;

    apb_rr_requester_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .req0   (req[0]),
        .req1   (req[1]),
        .write0 (wr[0]),
        .write1 (wr[1]),
        .addr0  (addr[0]),
        .addr1  (addr[1]),
        .wdata0 (wdata[0]),
        .wdata1 (wdata[1]),
        .lock0  (lk[0]),
        .lock1  (lk[1]),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .err0   (err0),
        .err1   (err1),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PRDATA (PRDATA),
        .PREADY (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Completer: PREADY after slv_wait ACCESS cycles; PRDATA = base + inc * completions.
    initial begin : completer
        PREADY  = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        slv_n   = 0;
        acc_cnt = 0;
        forever begin
            @(posedge PCLK);
            #2;
            if (PSEL && PENABLE) begin
                if (acc_cnt >= slv_wait) begin
                    PREADY = 1'b1;
                    PRDATA = slv_base + slv_inc * slv_n;
                    slv_n++;
                end else begin
                    PREADY = 1'b0;
                    PRDATA = 32'hDEAD_BEEF;
                end
                acc_cnt++;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
                acc_cnt = 0;
            end
        end
    end

    int unsigned rst_events;
    initial begin : rst_count
        rst_events = 0;
        forever begin
            @(negedge PRESETn);
            rst_events++;
        end
    end

    // Reference model: walks one whole transaction per grant as a timed sequence.
    logic        e_psel, e_pen, e_pwrite;
    logic [31:0] e_paddr, e_pwdata;
    logic [1:0]  e_ack, e_err;
    logic [31:0] e_rdata [2];
    int          m_last;
    bit          m_locked;

    initial begin : model
        int unsigned seen;
        bit pend, ab, have, is_wr;
        int w, waits;
        seen = 0; pend = 0;
        e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = 0; e_pwdata = 0;
        e_ack = 0; e_err = 0; e_rdata[0] = 0; e_rdata[1] = 0;
        m_last = 1; m_locked = 0;
        forever begin
            if (!pend) @(posedge PCLK);
            pend = 0;
            if (rst_events != seen) begin
                seen = rst_events;
                e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = 0; e_pwdata = 0;
                e_ack = 0; e_err = 0; e_rdata[0] = 0; e_rdata[1] = 0;
                m_last = 1; m_locked = 0;
            end
            if (!PRESETn) continue;
            if (m_locked && !req[m_last] && !lk[m_last]) m_locked = 0;
            have = 0; w = 0;
            if (m_locked) begin
                have = req[m_last]; w = m_last;
            end else if (req[0] && req[1]) begin
                have = 1; w = 1 - m_last;
            end else if (req[0] || req[1]) begin
                have = 1; w = req[1] ? 1 : 0;
            end
            if (!have) continue;
            m_last = w;
            is_wr = wr[w];
            e_paddr = addr[w]; e_pwdata = wdata[w]; e_pwrite = wr[w];
            e_psel = 1; e_pen = 0;
            @(posedge PCLK);
            if (rst_events != seen) begin pend = 1; continue; end
            e_pen = 1; waits = 0; ab = 0;
            forever begin
                @(posedge PCLK);
                if (rst_events != seen) begin ab = 1; break; end
                if (PREADY) begin
                    e_rdata[w] = is_wr ? 32'h0 : PRDATA;
                    e_err[w] = 0; m_locked = lk[w];
                    break;
                end
                if (waits == TIMEOUT - 1) begin
                    e_rdata[w] = 32'h0; e_err[w] = 1; m_locked = 0;
                    break;
                end
                waits++;
            end
            if (ab) begin pend = 1; continue; end
            e_psel = 0; e_pen = 0; e_ack[w] = 1;
            @(posedge PCLK);
            if (rst_events != seen) begin pend = 1; continue; end
            e_ack = 0; e_err = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        bit rs;
        rs = !PRESETn;
        chk("psel",    32'(PSEL),    rs ? 32'h0 : 32'(e_psel));
        chk("penable", 32'(PENABLE), rs ? 32'h0 : 32'(e_pen));
        chk("pwrite",  32'(PWRITE),  rs ? 32'h0 : 32'(e_pwrite));
        chk("paddr",   PADDR,        rs ? 32'h0 : e_paddr);
        chk("pwdata",  PWDATA,       rs ? 32'h0 : e_pwdata);
        chk("ack0",    32'(ack0),    rs ? 32'h0 : 32'(e_ack[0]));
        chk("ack1",    32'(ack1),    rs ? 32'h0 : 32'(e_ack[1]));
        chk("err0",    32'(err0),    rs ? 32'h0 : 32'(e_err[0]));
        chk("err1",    32'(err1),    rs ? 32'h0 : 32'(e_err[1]));
        chk("rdata0",  rdata0,       rs ? 32'h0 : e_rdata[0]);
        chk("rdata1",  rdata1,       rs ? 32'h0 : e_rdata[1]);
    endtask

    // One clock: compare on the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        @(negedge PCLK);
        compare_all();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_ack(input int max, output int who, output int cycles);
        who = -1; cycles = 0;
        for (int i = 0; i < max; i++) begin
            step();
            cycles++;
            if (ack0 || ack1) begin
                who = ack1 ? 1 : 0;
                return;
            end
        end
    endtask

    initial begin : stim
        int who, cyc, acc;
        n_pass = 0; n_total = 0;
        req = 0; wr = 0; lk = 0;
        addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
        slv_wait = 0; slv_base = 0; slv_inc = 0;
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        repeat (3) step();
        chk("rst_psel",  32'(PSEL), 32'h0);
        chk("rst_ack0",  32'(ack0), 32'h0);
        chk("rst_paddr", PADDR,     32'h0);
        PRESETn = 1'b1;
        step();

        // single zero-wait read
        req[0] = 1; wr[0] = 0; addr[0] = 32'h100; slv_base = 32'h00FF0000;
        step();
        chk("t1_setup_psel", 32'(PSEL),    32'h1);
        chk("t1_setup_pen",  32'(PENABLE), 32'h0);
        chk("t1_paddr",      PADDR,        32'h100);
        step();
        chk("t1_access_pen", 32'(PENABLE), 32'h1);
        step();
        chk("t1_ack0",  32'(ack0), 32'h1);
        chk("t1_rdata", rdata0,    32'h00FF0000);
        chk("t1_err0",  32'(err0), 32'h0);
        chk("t1_psel",  32'(PSEL), 32'h0);
        req[0] = 0;
        step();

        // contention from reset: both writers keep req high
        PRESETn = 1'b0;
        req = 2'b11; wr = 2'b11; addr[0] = 32'h100; addr[1] = 32'h100;
        wdata[0] = 32'h11; wdata[1] = 32'h22;
        repeat (2) step();
        PRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, who, cyc);
            chk("t2_who",    32'(who), 32'(k % 2));
            chk("t2_pwdata", PWDATA,   (k % 2) ? 32'h22 : 32'h11);
            chk("t2_gap",    32'(cyc), (k == 0) ? 32'd3 : 32'd4);
            if (k == 3) req = 0;
        end
        step();

        // locked burst by client 1 while client 0 waits
        req[1] = 1; wr[1] = 0; addr[1] = 32'h0; lk[1] = 1;
        slv_base = 32'ha0 - slv_n; slv_inc = 1;
        step();
        chk("t3_grant1", PADDR, 32'h0);
        req[0] = 1; wr[0] = 0; addr[0] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            wait_ack(10, who, cyc);
            chk("t3_who", 32'(who), (k < 3) ? 32'h1 : 32'h0);
            if (k < 3) chk("t3_rdata1", rdata1, 32'ha0 + 32'(k));
            else       chk("t3_rdata0", rdata0, 32'ha3);
            if (k == 1) lk[1] = 0;
            if (k == 2) req[1] = 0;
            if (k == 3) req[0] = 0;
        end
        slv_inc = 0;
        step();

        // timeout with lock requested: abort must also free the bus
        req[0] = 1; wr[0] = 0; addr[0] = 32'h300; lk[0] = 1; slv_wait = 1000;
        acc = 0; who = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (PSEL && PENABLE) acc++;
            if (ack0) begin who = 0; break; end
        end
        chk("t4_who",    32'(who),  32'h0);
        chk("t4_access", 32'(acc),  32'd16);
        chk("t4_err0",   32'(err0), 32'h1);
        chk("t4_rdata0", rdata0,    32'h0);
        chk("t4_psel",   32'(PSEL), 32'h0);
        req[0] = 0; req[1] = 1; wr[1] = 1; addr[1] = 32'h400; wdata[1] = 32'h55; slv_wait = 0;
        wait_ack(10, who, cyc);
        chk("t4_unlock_who", 32'(who),    32'h1);
        chk("t4_err1",       32'(err1),   32'h0);
        chk("t4_pwdata",     PWDATA,      32'h55);
        chk("t4_pwrite",     32'(PWRITE), 32'h1);
        req[1] = 0; lk[0] = 0;
        step();

        // three wait states
        req[0] = 1; wr[0] = 0; addr[0] = 32'h500; slv_wait = 3; slv_base = 32'hA5;
        acc = 0; who = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (PSEL && PENABLE) begin
                acc++;
                chk("t5_paddr",  PADDR,        32'h500);
                chk("t5_pwrite", 32'(PWRITE),  32'h0);
            end
            if (ack0) begin who = 0; break; end
        end
        chk("t5_who",    32'(who), 32'h0);
        chk("t5_access", 32'(acc), 32'd4);
        chk("t5_rdata0", rdata0,   32'hA5);
        req[0] = 0;
        step();

        // reset during ACCESS
        req[0] = 1; wr[0] = 0; addr[0] = 32'h600; slv_wait = 1000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (PENABLE) break;
        end
        chk("t6_in_access", 32'(PENABLE), 32'h1);
        #1 PRESETn = 1'b0;
        #1;
        chk("t6_async_psel", 32'(PSEL),    32'h0);
        chk("t6_async_pen",  32'(PENABLE), 32'h0);
        req[1] = 1; wr[1] = 0; addr[1] = 32'h700; slv_wait = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_noack", 32'({ack1, ack0}), 32'h0);
        end
        PRESETn = 1'b1;
        wait_ack(8, who, cyc);
        chk("t6_first_who", 32'(who), 32'h0);
        req[0] = 0;
        wait_ack(8, who, cyc);
        chk("t6_second_who", 32'(who), 32'h1);
        req[1] = 0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_rr_requester_arbiter.md
Name: apb_rr_requester_arbiter

Overview:
- Shares one APB3 completer port (register slave) between two simple request/acknowledge clients.
- Selects clients round-robin and drives the full SETUP/ACCESS sequence, one transfer at a time.
- Supports a per-client lock, so auto-incrementing registers can be read as an uninterrupted sequence.
- Aborts any access the completer leaves unanswered, using a PREADY timeout.

Parameters:
- ADDR_W, 32, width of PADDR and client addresses.
- DATA_W, 32, width of PWDATA, PRDATA and client data.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (legal range 2..255).

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset; one clock domain, reset is asynchronous and active-low.
- req0/req1  in  1  client N requests a transfer; held until its ack.
- write0/write1  in  1  1 = write, 0 = read; stable while reqN is high.
- addr0/addr1  in  ADDR_W  transfer address; stable while reqN is high.
- wdata0/wdata1  in  DATA_W  write data; stable while reqN is high.
- lock0/lock1  in  1  keep the grant after this transfer completes.
- ack0/ack1  out  1  one-cycle completion pulse.
- rdata0/rdata1  out  DATA_W  read data, valid while ackN is high; 0 for writes and errors.
- err0/err1  out  1  valid with ackN; 1 = timeout abort.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- All outputs are registered.
- Reset values: PSEL, PENABLE, PWRITE, ack*, err* = 0; PADDR, PWDATA, rdata* = 0.
- Internal reset values: state = IDLE, last_grant = 1 (client 0 wins first), locked = 0, tcnt = 0.
- States:
  - IDLE: evaluate requests.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - DONE: PSEL=PENABLE=0, ack of the winner = 1.
- IDLE, arbitration:
  - If locked, only the lock owner is eligible.
  - If the owner has req low and lock low in IDLE, clear locked and arbitrate normally in the same cycle.
  - Otherwise: a single requester wins; on contention the client != last_grant wins.
- IDLE -> SETUP: latch addr/wdata/write of the winner into PADDR/PWDATA/PWRITE; set last_grant = winner.
- SETUP -> ACCESS: unconditional after 1 cycle.
- ACCESS, PREADY=1 -> DONE:
  - Reads: rdataN <= PRDATA; writes: rdataN <= 0.
  - errN <= 0.
  - locked <= lockN of the winner.
- ACCESS, PREADY=0: tcnt increments.
  - When tcnt reaches TIMEOUT-1 with PREADY still low -> DONE with errN=1, rdataN=0, locked=0.
  - tcnt clears on entry to ACCESS.
- DONE -> IDLE: unconditional. req is not sampled in DONE, so a client keeping req high is treated as a new request in the following IDLE.
- Latency: req high in IDLE cycle n -> SETUP n+1 -> ACCESS n+2 -> ack at n+3 when PREADY=1 at n+2. Minimum 4 cycles per transfer.
- Address, data and direction outputs hold between transfers; only PSEL and PENABLE return to 0.
- PADDR, PWDATA and PWRITE are constant from SETUP through ACCESS, per the APB protocol.
- At most one ack is high in any cycle; ack and err are never high for a client that was not granted.
- Reset asserted mid-transfer:
  - Immediately clears PSEL/PENABLE and returns to IDLE.
  - The pending client receives no ack and must re-request after reset.
- Requests that drop before being granted are ignored. Dropping req while granted is a client protocol violation; the transfer still completes and acks.

Test Plan:
- Single read: req0, addr0=0x100, slave with zero wait states and PRDATA=0x00FF0000 -> PSEL at cycle n+1, PENABLE at n+2, ack0 at n+3 with rdata0=0x00FF0000, err0=0.
- Contention: req0 and req1 both high from reset, both writes (0x100 <- 0x11 and 0x100 <- 0x22), each keeping req high after ack -> grant order 0,1,0,1; PWDATA alternates 0x11/0x22; each ack 4 cycles apart.
- Lock sequence: client1 holds lock1=1 and issues three reads of addr 0x0, returning 0xa0, 0xa1, 0xa2, while req0 stays high -> client 0 is not granted until the transfer after lock1 falls.
- Timeout: slave holds PREADY=0, TIMEOUT=16 -> ACCESS lasts 16 cycles, then ack0=1, err0=1, rdata0=0, PSEL=0 in that cycle; lock is released.
- Wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA=0xA5 -> PADDR/PWRITE stable throughout; ack one cycle after PREADY with rdata=0xA5.
- Reset mid-ACCESS: PRESETn low while PENABLE=1 -> PSEL/PENABLE drop without waiting for a clock; no ack; after release, client 0 wins first again.
